// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing a + b + cin LSB first, one bit per clock, through one full_adder
// Ports: clk, rst (async, active high), start, a[WIDTH], b[WIDTH], cin -> busy, done, sum[WIDTH], cout
// Macro SERIAL_ADDER_OVF_EN adds output ovf: signed overflow, registered on the final bit
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rs_q, rs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic cy_q, cy_d, done_q, done_d, fa_s, fa_c, accept, last;
   full_adder u_fa (.x(ra_q[0]), .y(rb_q[0]), .z(cy_q), .s(fa_s), .c(fa_c));
   assign accept = state_q == IDLE && start;
   assign last   = state_q == RUN && cnt_q == CW'(WIDTH - 1);
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rs_d    = rs_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (accept) begin
         state_d = RUN;
         ra_d    = a;
         rb_d    = b;
         rs_d    = '0;
         cy_d    = cin;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         ra_d    = ra_q >> 1;
         rb_d    = rb_q >> 1;
         // new sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts
         rs_d    = WIDTH'({fa_s, rs_q} >> 1);
         cy_d    = fa_c;
         cnt_d   = cnt_q + CW'(1);
         state_d = last ? IDLE : RUN;
         done_d  = last;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rs_q    <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rs_q    <= rs_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   // on the last bit cy_q is the carry into the MSB and fa_c the carry out of it
   assign ovf_d = accept ? 1'b0 : last ? cy_q ^ fa_c : ovf_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif
   assign busy = state_q == RUN;
   assign done = done_q;
   assign sum  = rs_q;
   assign cout = cy_q;
endmodule

// full_adder: one-bit full adder, s = x ^ y ^ z, c = majority(x, y, z)
module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));
endmodule
